// File: rtl/clock_div_five.sv
// Divide clk_in by DIV: bit 0 retimed on rising edges, bit 1 the same waveform on falling edges.
// Optional CLKDIV5_FIFTY_EN adds clk_div_50 = bit0 | bit1 (a 50% duty clock when DIV=5, HIGH_CYCLES=2).
module clock_div_five #(
    parameter int DIV         = 5,
    parameter int HIGH_CYCLES = 2
) (
    input  logic       clk_in,
    input  logic       rst,
`ifdef CLKDIV5_FIFTY_EN
    output logic       clk_div_50,
`endif
    output logic [1:0] clk_div_5
);

    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
    localparam logic [CW-1:0] HIGH_CMP = CW'(HIGH_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q;

    always_comb begin
        cnt_d  = '0;
        rise_d = 1'b0;
        if (!rst) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            // Output decodes the next count so the wrap edge is also the rising edge of bit 0.
            rise_d = (cnt_d < HIGH_CMP);
        end
    end

    always_ff @(posedge clk_in) begin
        cnt_q  <= cnt_d;
        rise_q <= rise_d;
    end

    always_ff @(negedge clk_in) begin
        if (rst) fall_q <= 1'b0;
        else     fall_q <= rise_q;
    end

    assign clk_div_5 = {fall_q, rise_q};

`ifdef CLKDIV5_FIFTY_EN
    // The reset term masks a falling-edge copy that has not yet been cleared.
    assign clk_div_50 = (rise_q | fall_q) & ~rst;
`endif

endmodule

// File: tb/tb_clock_div_five.sv
// Bench for clock_div_five: default instance plus a DIV=3/HIGH_CYCLES=1 instance sharing clock and reset.
// Covers the CLKDIV5_FIFTY_EN output when that macro is defined.
module tb_clock_div_five;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic [1:0] div5_o;
    logic [1:0] div3_o;
    logic       c50_5, c50_3;

    always #15 clk_in = ~clk_in;

    clock_div_five dut5 (
        .clk_in    (clk_in),
        .rst       (rst),
`ifdef CLKDIV5_FIFTY_EN
        .clk_div_50(c50_5),
`endif
        .clk_div_5 (div5_o)
    );

    clock_div_five #(.DIV(3), .HIGH_CYCLES(1)) dut3 (
        .clk_in    (clk_in),
        .rst       (rst),
`ifdef CLKDIV5_FIFTY_EN
        .clk_div_50(c50_3),
`endif
        .clk_div_5 (div3_o)
    );

`ifndef CLKDIV5_FIFTY_EN
    assign c50_5 = 1'b0;
    assign c50_3 = 1'b0;
`endif

    typedef struct {
        logic rst;
        int   cnt5;
        logic b5;
        int   cnt3;
        logic b3;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int checks = 0;
    int errors = 0;
    logic meas_en = 1'b0;
    time  rise_t  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input int c5, input logic b5,
                                input int c3, input logic b3);
        vec_t v;
        v.rst = r; v.cnt5 = c5; v.b5 = b5; v.cnt3 = c3; v.b3 = b3;
        vecs.push_back(v);
    endfunction

`ifdef CLKDIV5_FIFTY_EN
    // High-time measurement of clk_div_50 in the free-running window: 2.5 cycles of 30 ns.
    always @(posedge c50_5) rise_t = $time;
    always @(negedge c50_5) if (meas_en) chk("c50_high_ns", int'($time - rise_t), 75);
`endif

    initial begin
        vec_t e;
        logic prev_b5, prev_b3;
        int   k;

        // Reset for two periods.
        add(1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0);
        // 20 free-running cycles: DIV=5 gives 1,0,0,0,1 ... ; DIV=3,HIGH=1 gives 0,0,1 ...
        for (int i = 1; i <= 20; i++)
            add(0, i % 5, (i % 5) < 2, i % 3, (i % 3) < 1);
        // Reset while default bit 0 is high, then the restart.
        add(1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0);
        add(0, 2, 0, 2, 0);
        add(0, 3, 0, 0, 1);
        add(0, 4, 0, 1, 0);
        add(0, 0, 1, 2, 0);
        add(0, 1, 1, 0, 1);

        prev_b5 = 1'b0;
        prev_b3 = 1'b0;
        k = 0;
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            sb.push_back(vecs[i]);
            meas_en = (k >= 4 && k <= 20);
            @(posedge clk_in);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
                break;
            end
            e = sb.pop_front();
            chk($sformatf("cnt5[%0d]", k), int'(dut5.cnt_q), e.cnt5);
            chk($sformatf("bit0_5[%0d]", k), int'(div5_o[0]), int'(e.b5));
            chk($sformatf("cnt3[%0d]", k), int'(dut3.cnt_q), e.cnt3);
            chk($sformatf("bit0_3[%0d]", k), int'(div3_o[0]), int'(e.b3));
            if (int'(dut5.cnt_q) >= 5) chk("cnt5_bound", int'(dut5.cnt_q), 4);
            if (int'(dut3.cnt_q) >= 3) chk("cnt3_bound", int'(dut3.cnt_q), 2);
`ifdef CLKDIV5_FIFTY_EN
            chk($sformatf("c50_rise[%0d]", k), int'(c50_5),
                e.rst ? 0 : int'(e.b5 | prev_b5));
            chk($sformatf("c50_3_rise[%0d]", k), int'(c50_3),
                e.rst ? 0 : int'(e.b3 | prev_b3));
`endif
            @(negedge clk_in);
            #1;
            prev_b5 = e.rst ? 1'b0 : e.b5;
            prev_b3 = e.rst ? 1'b0 : e.b3;
            chk($sformatf("bit1_5[%0d]", k), int'(div5_o[1]), int'(prev_b5));
            chk($sformatf("bit1_3[%0d]", k), int'(div3_o[1]), int'(prev_b3));
`ifdef CLKDIV5_FIFTY_EN
            chk($sformatf("c50_fall[%0d]", k), int'(c50_5), e.rst ? 0 : int'(e.b5));
`endif
            #5;
            k++;
        end
        meas_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/clock_div_five.md
CLOCK_DIV_FIVE -- requirements
Module: clock_div_five

Interface
REQ-001 The block SHALL have parameter DIV, default 5, meaning the division ratio, legal range 3..16.
REQ-002 The block SHALL have parameter HIGH_CYCLES, default 2, meaning the number of clk_in periods per output period that clk_div_5[0] is high, legal range 1..DIV-1.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock; every flop SHALL be clocked by clk_in, on its rising or its falling edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port clk_div_5, output, 2 bits: bit 0 is the divided clock generated on rising edges, bit 1 is the same waveform retimed on falling edges.
REQ-006 With CLKDIV5_FIFTY_EN defined, the block SHALL also have port clk_div_50, output, 1 bit: the combined divided clock.

Function
REQ-007 The block SHALL keep a counter cnt of width clog2(DIV), updated on each rising edge of clk_in.
- cnt SHALL step 0, 1, ... DIV-1, then wrap to 0.
- cnt SHALL never hold a value of DIV or above.
REQ-008 clk_div_5[0] SHALL be a registered output updated on rising edges, set to 1 when the new cnt value is below HIGH_CYCLES, otherwise 0.
- No glitches; no combinational path from cnt to the output.
REQ-009 With defaults, clk_div_5[0] SHALL have period 5 clk_in cycles and be high for 2 of them (duty 2/5).
REQ-010 clk_div_5[1] SHALL be a flop that takes the value of clk_div_5[0] on each falling edge of clk_in.
- It lags bit 0 by half a clk_in period; period and duty match bit 0.
REQ-011 Both output bits SHALL have exactly one edge source each; neither bit SHALL be driven by a gated clock or a latch.
REQ-012 The cnt wrap (DIV-1 to 0) SHALL occur on the same rising edge that sets clk_div_5[0] to 1.

Reset
REQ-013 On a rising edge with rst=1, cnt SHALL become 0 and clk_div_5[0] SHALL become 0.
REQ-014 On a falling edge with rst=1, clk_div_5[1] SHALL become 0.
REQ-015 Reset SHALL take priority over counting on every edge, including a reset asserted mid-period, which truncates the current output pulse.
REQ-016 On the first rising edge with rst=0 after reset, cnt SHALL become 1 and clk_div_5[0] SHALL become 1.
- With defaults, bit 0 then follows the sequence 1,0,0,0,1,1,0,0,0,1,1,... per clk_in cycle.
REQ-017 Before the first reset, output values are undefined; the bench SHALL apply reset for at least 1 full clk_in period.

Configuration
REQ-018 Macro CLKDIV5_FIFTY_EN:
- When defined, clk_div_50 SHALL equal clk_div_5[0] OR clk_div_5[1]; with DIV=5 and HIGH_CYCLES=2 this gives a 50% duty (2.5 of 5 cycles high) divide-by-5 clock.
- clk_div_50 SHALL be 0 during reset.
- When not defined, clk_div_50 SHALL be absent and the outputs SHALL be only the 2-bit clk_div_5.

Verification
REQ-019 Hold rst=1 for 2 clk_in periods -> clk_div_5=2'b00 and cnt=0 after the first rising and first falling edge.
REQ-020 Release rst and run 20 cycles -> bit 0 is high on 2 of every 5 rising-edge samples (pattern 1,0,0,0,1) and bit 1 matches bit 0 half a period later.
REQ-021 Assert rst for 1 cycle while bit 0=1 -> bit 0=0 at the next rising edge, bit 1=0 at the next falling edge, and the sequence restarts with 1,0,0,0,1,1.
REQ-022 With CLKDIV5_FIFTY_EN defined, run 20 cycles -> clk_div_50 is high for exactly 75 ns of every 150 ns period with a 30 ns clk_in.
REQ-023 Set DIV=3 and HIGH_CYCLES=1 -> bit 0 has a period of 3 cycles with 1 cycle high, and cnt never reaches 3.
REQ-024 Over all runs -> cnt stays below DIV, and no output toggles more than once per clk_in edge.
